// File: rtl/cpu_imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// The LDR_* state encodings that used to live in cpu_defs.vh are now this enum.
package cpu_imem_loader_pkg;

    typedef enum logic [1:0] {
        LDR_IDLE  = 2'd0,
        LDR_LOAD  = 2'd1,
        LDR_FLUSH = 2'd2
    } ldr_state_e;

endpackage

// File: rtl/cpu_imem_loader_if.sv
// Loader control, instruction stream and IMEM write-port bundle.
// The host modport drives the requests and the stream; the loader modport drives the rest.
interface cpu_imem_loader_if #(
    parameter int unsigned AWIDTH = 8,
    parameter int unsigned DWIDTH = 13
);
    logic              START;
    logic [AWIDTH:0]   LEN;
    logic              ABORT;
    logic [DWIDTH-1:0] IN_DATA;
    logic              IN_VALID;
    logic              IN_READY;
    logic [AWIDTH-1:0] IMEM_ADDR;
    logic [DWIDTH-1:0] IMEM_DATA;
    logic              IMEM_WE;
    logic              CPU_HOLD;
    logic              BUSY;
    logic              DONE;
    logic              ERR;

    modport master (
        output START, LEN, ABORT, IN_DATA, IN_VALID,
        input  IN_READY, IMEM_ADDR, IMEM_DATA, IMEM_WE, CPU_HOLD, BUSY, DONE, ERR
    );

    modport slave (
        input  START, LEN, ABORT, IN_DATA, IN_VALID,
        output IN_READY, IMEM_ADDR, IMEM_DATA, IMEM_WE, CPU_HOLD, BUSY, DONE, ERR
    );
endinterface

// File: rtl/cpu_ldr_timer.sv
// Clearable saturating idle counter; EXPIRED flags the idle cycle that reaches TIMEOUT.
module cpu_ldr_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    input  logic INC,
    output logic EXPIRED
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (CLR) begin
            count <= '0;
        end else if (INC && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    // Combinational so the loader leaves LOAD on the edge that completes the TIMEOUT-th idle cycle.
    assign EXPIRED = INC && !CLR && (count >= LIMIT - 1'b1);
endmodule

// File: rtl/cpu_imem_loader.sv
// Program loader: streams instruction words into IMEM from address 0 and holds the
// CPU in reset until a complete image has been written.
module cpu_imem_loader
    import cpu_imem_loader_pkg::*;
#(
    parameter int unsigned AWIDTH        = 8,
    parameter int unsigned DWIDTH        = 13,
    parameter int unsigned TIMEOUT       = 255,
    parameter int unsigned HOLD_AT_RESET = 1
) (
    input logic              CLK,
    input logic              RST,
    cpu_imem_loader_if.slave bus
);
    localparam logic [AWIDTH:0] MAX_LEN = {1'b1, {AWIDTH{1'b0}}};

    ldr_state_e        state;
    logic [AWIDTH:0]   len_q;
    logic [AWIDTH:0]   cnt;
    logic              hold_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              we_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] data_q;

    logic in_load;
    logic xfer;
    logic write;
    logic bad_len;
    logic last;
    logic expired;

    assign in_load = (state == LDR_LOAD);
    assign xfer    = in_load && bus.IN_VALID;
    assign write   = xfer && !bus.ABORT;
    assign bad_len = (bus.LEN == '0) || (bus.LEN > MAX_LEN);
    assign last    = (cnt == len_q - 1'b1);

    cpu_ldr_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .CLK     (CLK),
        .RST     (RST),
        .CLR     (!in_load || xfer),
        .INC     (in_load && !xfer),
        .EXPIRED (expired)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= LDR_IDLE;
            len_q  <= '0;
            cnt    <= '0;
            hold_q <= (HOLD_AT_RESET != 0);
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                LDR_IDLE: begin
                    if (bus.START) begin
                        if (bad_len) begin
                            err_q <= 1'b1;
                        end else begin
                            state  <= LDR_LOAD;
                            len_q  <= bus.LEN;
                            cnt    <= '0;
                            hold_q <= 1'b1;
                            err_q  <= 1'b0;
                            busy_q <= 1'b1;
                        end
                    end
                end
                LDR_LOAD: begin
                    // Abort wins over both a concurrent transfer and the timeout.
                    if (bus.ABORT) begin
                        state  <= LDR_IDLE;
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end else if (xfer) begin
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            state <= LDR_FLUSH;
                        end
                    end else if (expired) begin
                        state  <= LDR_IDLE;
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                LDR_FLUSH: begin
                    state  <= LDR_IDLE;
                    hold_q <= 1'b0;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= LDR_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q <= write;
            if (write) begin
                addr_q <= cnt[AWIDTH-1:0];
                data_q <= bus.IN_DATA;
            end
        end
    end

    assign bus.IN_READY  = in_load;
    assign bus.IMEM_WE   = we_q;
    assign bus.IMEM_ADDR = addr_q;
    assign bus.IMEM_DATA = data_q;
    assign bus.CPU_HOLD  = hold_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.ERR       = err_q;
endmodule

// File: tb/tb_cpu_imem_loader.sv
// Directed self-checking bench for cpu_imem_loader (AWIDTH=8, DWIDTH=13, TIMEOUT=8).
module tb_cpu_imem_loader;
    logic CLK;
    logic RST;

    int checks;
    int failures;

    logic [7:0]  wr_addr [0:511];
    logic [12:0] wr_data [0:511];
    int          wr_n;
    int          done_n;

    cpu_imem_loader_if #(.AWIDTH(8), .DWIDTH(13)) bus ();

    cpu_imem_loader #(
        .AWIDTH        (8),
        .DWIDTH        (13),
        .TIMEOUT       (8),
        .HOLD_AT_RESET (1)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        wr_n   = 0;
        done_n = 0;
    end

    // Write/DONE log, sampled on the edge that ends each cycle.
    always @(posedge CLK) begin
        if (bus.IMEM_WE === 1'b1 && wr_n < 512) begin
            wr_addr[wr_n] <= bus.IMEM_ADDR;
            wr_data[wr_n] <= bus.IMEM_DATA;
            wr_n          <= wr_n + 1;
        end
        if (bus.DONE === 1'b1) begin
            done_n <= done_n + 1;
        end
    end

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input logic [8:0] len);
        bus.START = 1'b1;
        bus.LEN   = len;
        tick();
        bus.START = 1'b0;
    endtask

    initial begin
        int base;
        int dbase;
        int k;
        int bad;
        logic [5:0] pat;

        checks   = 0;
        failures = 0;
        RST          = 1'b1;
        bus.START    = 1'b0;
        bus.LEN      = '0;
        bus.ABORT    = 1'b0;
        bus.IN_DATA  = '0;
        bus.IN_VALID = 1'b0;

        // 1: reset values
        #12;
        chk("rst_hold",  32'(bus.CPU_HOLD), 1);
        chk("rst_ready", 32'(bus.IN_READY), 0);
        chk("rst_we",    32'(bus.IMEM_WE),  0);
        chk("rst_err",   32'(bus.ERR),      0);
        chk("rst_done",  32'(bus.DONE),     0);
        chk("rst_busy",  32'(bus.BUSY),     0);
        @(negedge CLK);
        RST = 1'b0;
        tick();

        // 2: LEN=4 back-to-back
        start_load(9'd4);
        chk("t2_busy",  32'(bus.BUSY),     1);
        chk("t2_ready", 32'(bus.IN_READY), 1);
        bus.IN_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.IN_DATA = 13'h1A01 + 13'(i);
            tick();
            chk("t2_we",   32'(bus.IMEM_WE),   1);
            chk("t2_addr", 32'(bus.IMEM_ADDR), 32'(i));
            chk("t2_data", 32'(bus.IMEM_DATA), 32'h1A01 + 32'(i));
        end
        chk("t2_flush_ready", 32'(bus.IN_READY), 0);
        chk("t2_flush_done",  32'(bus.DONE),     0);
        chk("t2_flush_hold",  32'(bus.CPU_HOLD), 1);
        bus.IN_VALID = 1'b0;
        tick();
        chk("t2_done",      32'(bus.DONE),     1);
        chk("t2_hold",      32'(bus.CPU_HOLD), 0);
        chk("t2_we_off",    32'(bus.IMEM_WE),  0);
        chk("t2_busy_off",  32'(bus.BUSY),     0);
        tick();
        chk("t2_done_pulse", 32'(bus.DONE),     0);
        chk("t2_hold_stay",  32'(bus.CPU_HOLD), 0);

        // 3: LEN=3, IN_VALID 1,0,0,1,0,1
        base  = wr_n;
        dbase = done_n;
        start_load(9'd3);
        pat = 6'b101001;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            bus.IN_VALID = pat[i];
            bus.IN_DATA  = 13'h0B01 + 13'(k);
            tick();
            if (pat[i]) k++;
        end
        bus.IN_VALID = 1'b0;
        tick();
        tick();
        tick();
        chk("t3_writes", 32'(wr_n - base), 3);
        chk("t3_addr0",  32'(wr_addr[base]),     0);
        chk("t3_addr1",  32'(wr_addr[base + 1]), 1);
        chk("t3_addr2",  32'(wr_addr[base + 2]), 2);
        chk("t3_data2",  32'(wr_data[base + 2]), 32'h0B03);
        chk("t3_done",   32'(done_n - dbase), 1);
        chk("t3_err",    32'(bus.ERR), 0);

        // 4: timeout after 8 idle cycles
        base  = wr_n;
        dbase = done_n;
        start_load(9'd5);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 13'h0C01;
        tick();
        bus.IN_DATA  = 13'h0C02;
        tick();
        bus.IN_VALID = 1'b0;
        repeat (7) tick();
        chk("t4_busy_7", 32'(bus.BUSY), 1);
        tick();
        chk("t4_busy_8", 32'(bus.BUSY),     0);
        chk("t4_err",    32'(bus.ERR),      1);
        chk("t4_hold",   32'(bus.CPU_HOLD), 1);
        chk("t4_ready",  32'(bus.IN_READY), 0);
        tick();
        chk("t4_writes", 32'(wr_n - base), 2);
        chk("t4_nodone", 32'(done_n - dbase), 0);

        // 5: full 256-word load, then length boundaries
        base  = wr_n;
        dbase = done_n;
        start_load(9'd256);
        chk("t5_err_clr", 32'(bus.ERR), 0);
        bus.IN_VALID = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.IN_DATA = 13'h1000 + 13'(i);
            tick();
        end
        bus.IN_VALID = 1'b0;
        tick();
        tick();
        tick();
        chk("t5_writes", 32'(wr_n - base), 256);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (wr_addr[base + i] !== 8'(i)) bad++;
        end
        chk("t5_addr_seq",  32'(bad), 0);
        chk("t5_last_addr", 32'(wr_addr[base + 255]), 32'hFF);
        chk("t5_last_data", 32'(wr_data[base + 255]), 32'h10FF);
        chk("t5_done",      32'(done_n - dbase), 1);
        chk("t5_hold",      32'(bus.CPU_HOLD), 0);

        start_load(9'd0);
        chk("t5_len0_err",  32'(bus.ERR),      1);
        chk("t5_len0_busy", 32'(bus.BUSY),     0);
        chk("t5_len0_hold", 32'(bus.CPU_HOLD), 0);

        start_load(9'd1);
        chk("t5_len1_err", 32'(bus.ERR), 0);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 13'h0001;
        tick();
        bus.IN_VALID = 1'b0;
        chk("t5_len1_ready", 32'(bus.IN_READY),  0);
        chk("t5_len1_we",    32'(bus.IMEM_WE),   1);
        chk("t5_len1_addr",  32'(bus.IMEM_ADDR), 0);
        tick();
        chk("t5_len1_done",  32'(bus.DONE), 1);

        start_load(9'd257);
        chk("t5_len257_err",  32'(bus.ERR),  1);
        chk("t5_len257_busy", 32'(bus.BUSY), 0);

        // 6: reset mid-load, clean reload, abort with a concurrent transfer
        start_load(9'd4);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 13'h0A01;
        tick();
        bus.IN_DATA  = 13'h0A02;
        tick();
        RST = 1'b1;
        #1;
        chk("t6_rst_hold",  32'(bus.CPU_HOLD),  1);
        chk("t6_rst_ready", 32'(bus.IN_READY),  0);
        chk("t6_rst_we",    32'(bus.IMEM_WE),   0);
        chk("t6_rst_busy",  32'(bus.BUSY),      0);
        chk("t6_rst_err",   32'(bus.ERR),       0);
        chk("t6_rst_addr",  32'(bus.IMEM_ADDR), 0);
        chk("t6_rst_data",  32'(bus.IMEM_DATA), 0);
        bus.IN_VALID = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        tick();

        start_load(9'd2);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 13'h0D01;
        tick();
        bus.START    = 1'b1;
        bus.LEN      = 9'd0;
        bus.IN_DATA  = 13'h0D02;
        tick();
        bus.START    = 1'b0;
        bus.IN_VALID = 1'b0;
        chk("t6_start_ign", 32'(bus.ERR),       0);
        chk("t6_re_addr",   32'(bus.IMEM_ADDR), 1);
        chk("t6_re_data",   32'(bus.IMEM_DATA), 32'h0D02);
        tick();
        chk("t6_re_done",   32'(bus.DONE),     1);
        chk("t6_re_hold",   32'(bus.CPU_HOLD), 0);

        base = wr_n;
        start_load(9'd3);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 13'h0E01;
        tick();
        bus.ABORT    = 1'b1;
        bus.IN_DATA  = 13'h0E02;
        tick();
        bus.ABORT    = 1'b0;
        bus.IN_VALID = 1'b0;
        chk("t6_abort_we",   32'(bus.IMEM_WE),  0);
        chk("t6_abort_err",  32'(bus.ERR),      1);
        chk("t6_abort_busy", 32'(bus.BUSY),     0);
        chk("t6_abort_hold", 32'(bus.CPU_HOLD), 1);
        tick();
        chk("t6_abort_writes", 32'(wr_n - base), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
